// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 binary multiplier.
// The format is parameterised by exponent and fraction width, and rounding is round-to-nearest-even.
// Operands and results use a valid/ready stream. An opaque tag travels with each operation.
// Subnormal inputs are normalised on entry. Subnormal results are flushed to signed zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW2  = EXP_W + 2;          // signed exponent width inside the pipe
  localparam int MW1  = MAN_W + 1;          // significand width including the hidden bit
  localparam int PW   = 2 * MW1;            // full product width
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;       // all-ones exponent: inf/NaN

  // Operand class after the special cases have been resolved. K_NUM takes the arithmetic path.
  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_e;

  function automatic kind_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    kind_e k;
    k = K_NUM;
    if (e == {EXP_W{1'b1}}) begin
      if (f == '0) k = K_INF;
      else         k = K_NAN;
    end else if (e == '0 && f == '0) begin
      k = K_ZERO;
    end
    return k;
  endfunction

  // Returns the significand with its leading one at bit MAN_W, and the matching unbiased-offset exponent.
  // A subnormal is shifted up by its leading-zero count. Its exponent becomes 1-lz, which may be negative.
  function automatic void unpack(input  logic [EXP_W-1:0]      e,
                                 input  logic [MAN_W-1:0]      f,
                                 output logic signed [EW2-1:0] eo,
                                 output logic [MAN_W:0]        mo);
    logic [MAN_W:0] m;
    int             lz;
    logic           found;
    m     = {1'b0, f};
    lz    = 0;
    found = 1'b0;
    if (e != '0) begin
      eo = {2'b00, e};
      mo = {1'b1, f};
    end else begin
      for (int i = MAN_W; i >= 0; i--) begin
        if (!found) begin
          if (m[i]) found = 1'b1;
          else      lz = lz + 1;
        end
      end
      mo = m << lz;
      eo = EW2'(1 - lz);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline control: a single global stall. The output register frees up when it is empty or being consumed.
  // ---------------------------------------------------------------------------
  logic [2:0] vld_q;          // [0]=S1 regs, [1]=S2 regs, [2]=output regs
  logic       advance;

  assign advance   = !vld_q[2] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[2];

  // ---------------------------------------------------------------------------
  // S1: unpack, classify, normalise subnormals, resolve special cases
  // ---------------------------------------------------------------------------
  logic                  sa, sb;
  logic [EXP_W-1:0]      ea_f, eb_f;
  logic [MAN_W-1:0]      fa, fb;
  kind_e                 ka, kb, s1_kind_d;
  logic signed [EW2-1:0] s1_ea_d, s1_eb_d;
  logic [MAN_W:0]        s1_ma_d, s1_mb_d;

  assign {sa, ea_f, fa} = in_a;
  assign {sb, eb_f, fb} = in_b;

  // Classify both operands. NaN and inf*0 take priority over inf, and inf takes priority over zero.
  always_comb begin
    ka = classify(ea_f, fa);
    kb = classify(eb_f, fb);
    unpack(ea_f, fa, s1_ea_d, s1_ma_d);
    unpack(eb_f, fb, s1_eb_d, s1_mb_d);
    if (ka == K_NAN || kb == K_NAN ||
        (ka == K_INF && kb == K_ZERO) || (ka == K_ZERO && kb == K_INF))
      s1_kind_d = K_NAN;
    else if (ka == K_INF || kb == K_INF)
      s1_kind_d = K_INF;
    else if (ka == K_ZERO || kb == K_ZERO)
      s1_kind_d = K_ZERO;
    else
      s1_kind_d = K_NUM;
  end

  logic                  s1_sign_q;
  kind_e                 s1_kind_q;
  logic signed [EW2-1:0] s1_ea_q, s1_eb_q;
  logic [MAN_W:0]        s1_ma_q, s1_mb_q;
  logic [TAG_W-1:0]      s1_tag_q;

  // ---------------------------------------------------------------------------
  // S2: significand product and biased exponent sum
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         s2_p_d;
  logic signed [EW2-1:0] s2_e_d;

  assign s2_p_d = PW'(s1_ma_q) * PW'(s1_mb_q);
  assign s2_e_d = s1_ea_q + s1_eb_q - EW2'(BIAS);

  logic                  s2_sign_q;
  kind_e                 s2_kind_q;
  logic signed [EW2-1:0] s2_e_q;
  logic [PW-1:0]         s2_p_q;
  logic [TAG_W-1:0]      s2_tag_q;

  // ---------------------------------------------------------------------------
  // S3: normalise, round to nearest even, detect range, pack
  // ---------------------------------------------------------------------------
  logic [PW-1:0]         norm;
  logic signed [EW2-1:0] e_n, e_f;
  logic                  g_bit, r_bit, s_bit, lsb, rnd_up, inx;
  logic [MAN_W+1:0]      mr;
  logic [MAN_W-1:0]      frac;
  logic [W-1:0]          res_d;
  logic [3:0]            flags_d;

  // The product of two normalised significands lies in [1,4). Align its leading one to bit PW-1.
  // Then round away the lower MAN_W+1 bits and override the arithmetic result for special and out-of-range values.
  always_comb begin
    norm    = s2_p_q[PW-1] ? s2_p_q : {s2_p_q[PW-2:0], 1'b0};
    e_n     = s2_e_q + (s2_p_q[PW-1] ? EW2'(1) : EW2'(0));
    lsb     = norm[PW-1-MAN_W];
    g_bit   = norm[PW-2-MAN_W];
    r_bit   = norm[PW-3-MAN_W];
    s_bit   = |norm[PW-4-MAN_W:0];
    rnd_up  = g_bit && (r_bit || s_bit || lsb);
    inx     = g_bit || r_bit || s_bit;
    mr      = {1'b0, norm[PW-1 -: MW1]} + (MAN_W+2)'(rnd_up);
    // A carry out of rounding means the significand became exactly 2.0, so the fraction is zero.
    e_f     = e_n + (mr[MAN_W+1] ? EW2'(1) : EW2'(0));
    frac    = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    res_d   = '0;
    flags_d = 4'b0000;
    case (s2_kind_q)
      K_NAN: begin
        res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = 4'b1000;
      end
      K_INF:  res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (e_f >= EW2'(EMAX)) begin
          res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (e_f <= EW2'(0)) begin
          res_d   = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          res_d   = {s2_sign_q, e_f[EXP_W-1:0], frac};
          flags_d = {3'b000, inx};
        end
      end
    endcase
  end

  logic [W-1:0]     res_q;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]       flags_q;

  assign out_res   = res_q;
  assign out_tag   = tag_q;
  assign out_flags = flags_q;

  // All stages move together on advance. Data registers load only when their source stage holds a valid op.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0;
      s1_kind_q <= K_NUM;
      s1_ea_q   <= '0;
      s1_eb_q   <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_tag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_kind_q <= K_NUM;
      s2_e_q    <= '0;
      s2_p_q    <= '0;
      s2_tag_q  <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      flags_q   <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[1:0], in_valid};
      if (in_valid) begin
        s1_sign_q <= sa ^ sb;
        s1_kind_q <= s1_kind_d;
        s1_ea_q   <= s1_ea_d;
        s1_eb_q   <= s1_eb_d;
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_tag_q  <= in_tag;
      end
      if (vld_q[0]) begin
        s2_sign_q <= s1_sign_q;
        s2_kind_q <= s1_kind_q;
        s2_e_q    <= s2_e_d;
        s2_p_q    <= s2_p_d;
        s2_tag_q  <= s1_tag_q;
      end
      if (vld_q[1]) begin
        res_q   <= res_d;
        tag_q   <= s2_tag_q;
        flags_q <= flags_d;
      end
    end
  end

  // Offered operands must be fully defined.
  always_ff @(posedge clk) begin
    if (!rst && in_valid)
      assert (!$isunknown({in_a, in_b, in_tag}));
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (binary32). The expected values are worked out by hand in the comments.
module tb_fp_mul_pipe;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  in_tag, out_tag, out_flags;
  int          n_checks, n_fail;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op in cycle 0 on an empty pipe with out_ready=1 and returns the result and the cycle index it appeared in.
  // Called and returns 1 time unit after a rising edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       output logic [31:0] res, output logic [3:0] rtag, output logic [3:0] flg,
                       output int lat);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res; rtag = out_tag; flg = out_flags;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_res !== 32'h0) begin n_fail++; $display("FAIL reset_out_res: got %h want 0", out_res); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_checks++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL reset_out_flags: got %h want 0", out_flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] t, f; int l;
    // 1.5 * 2.0 = 3.0
    do_op(32'h3FC00000, 32'h40000000, 4'd3, r, t, f, l);
    n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL basic_res: got %h want 40400000", r); end
    n_checks++; if (f !== 4'h0) begin n_fail++; $display("FAIL basic_flags: got %h want 0", f); end
    n_checks++; if (t !== 4'd3) begin n_fail++; $display("FAIL basic_tag: got %0d want 3", t); end
    n_checks++; if (l !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", l); end
    // -1.5 * 2.0 = -3.0
    do_op(32'hBFC00000, 32'h40000000, 4'd7, r, t, f, l);
    n_checks++; if (r !== 32'hC0400000) begin n_fail++; $display("FAIL basic_neg_res: got %h want c0400000", r); end
    n_checks++; if (t !== 4'd7) begin n_fail++; $display("FAIL basic_neg_tag: got %0d want 7", t); end
  endtask

  task automatic test_special();
    logic [31:0] va [4], vb [4], ve [4];
    logic [3:0]  vf [4];
    logic [31:0] r; logic [3:0] t, f; int l;
    // inf*0 -> qNaN invalid; -inf*2 -> -inf; NaN*1 -> qNaN invalid; -0*3 -> -0
    va = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h80000000};
    vb = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h40400000};
    ve = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
    vf = '{4'h8, 4'h0, 4'h8, 4'h0};
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 4'(i), r, t, f, l);
      n_checks++; if (r !== ve[i]) begin n_fail++; $display("FAIL special_res[%0d]: got %h want %h", i, r, ve[i]); end
      n_checks++; if (f !== vf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %h want %h", i, f, vf[i]); end
    end
  endtask

  task automatic test_range();
    logic [31:0] va [5], vb [5], ve [5];
    logic [3:0]  vf [5];
    logic [31:0] r; logic [3:0] t, f; int l;
    // 2^127*2 overflow (+/-); 2^-126*0.5 underflow (+/-);
    // subnormal 2^-127 * 2^23 = 2^-104 -> exponent field 23 -> 0x0B800000
    va = '{32'h7F000000, 32'hFF000000, 32'h00800000, 32'h80800000, 32'h00400000};
    vb = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000, 32'h4B000000};
    ve = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h0B800000};
    vf = '{4'h5, 4'h5, 4'h3, 4'h3, 4'h0};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 4'(i), r, t, f, l);
      n_checks++; if (r !== ve[i]) begin n_fail++; $display("FAIL range_res[%0d]: got %h want %h", i, r, ve[i]); end
      n_checks++; if (f !== vf[i]) begin n_fail++; $display("FAIL range_flags[%0d]: got %h want %h", i, f, vf[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va [5], vb [5], ve [5];
    logic [3:0]  vf [5];
    logic [31:0] r; logic [3:0] t, f; int l;
    // (1+2^-23)^2: 2^-46 dropped. (1.5+2^-23)^2: above half, round up.
    // (2-2^-23)^2: below half. (1+2^-12)^2: exact tie with even lsb, stays.
    // (1+2^-12)(1+3*2^-12): exact tie with odd lsb, rounds up to even.
    va = '{32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF, 32'h3F800800, 32'h3F800800};
    vb = '{32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF, 32'h3F800800, 32'h3F801800};
    ve = '{32'h3F800002, 32'h40100002, 32'h407FFFFE, 32'h3F801000, 32'h3F802002};
    vf = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 4'(i), r, t, f, l);
      n_checks++; if (r !== ve[i]) begin n_fail++; $display("FAIL round_res[%0d]: got %h want %h", i, r, ve[i]); end
      n_checks++; if (f !== vf[i]) begin n_fail++; $display("FAIL round_flags[%0d]: got %h want %h", i, f, vf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [6], ve [6], gr [6];
    logic [3:0]  gt [6];
    int          idx, ngot;
    logic        acc;
    // k * 2.0 for k = 1..6
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    ve = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};
    for (int i = 0; i < 6; i++) begin gr[i] = '0; gt[i] = '0; end
    idx = 0; ngot = 0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 6);
      if (idx < 6) begin in_a = va[idx]; in_b = 32'h40000000; in_tag = 4'(idx); end
      #1;
      if (c == 3 || c == 4) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready c%0d: got %b want 0", c, in_ready); end
      end
      if (c == 3) begin
        n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_accepts_before_stall: got %0d want 3", idx); end
      end
      if (out_valid && out_ready && ngot < 6) begin gr[ngot] = out_res; gt[ngot] = out_tag; ngot++; end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (ngot !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", ngot); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (gt[i] !== 4'(i)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, gt[i], i); end
      n_checks++; if (gr[i] !== ve[i]) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h want %h", i, gr[i], ve[i]); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cnt;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 4'(8 + c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_res !== 32'h0) begin n_fail++; $display("FAIL rstmid_out_res: got %h want 0", out_res); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d results want 0", cnt); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_special();
    test_range();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
